// File: rtl/ex_issue_ctrl_if.sv
// ID/EX issue-control bundle: ID instruction fields, LS handshake, flush and
// the registered forwarding / mul-div control outputs of ex_issue_ctrl.
interface ex_issue_ctrl_if;
  logic       i_id_valid;
  logic       o_id_ready;
  logic [4:0] i_id_rs1_addr;
  logic [4:0] i_id_rs2_addr;
  logic       i_id_rs1_ren;
  logic       i_id_rs2_ren;
  logic [4:0] i_id_rd_addr;
  logic       i_id_rd_wen;
  logic       i_id_mem_read;
  logic       i_id_is_muldiv;
  logic       i_id_is_div;
  logic       i_ls_ready;
  logic       i_flush;
  logic       o_ex_valid;
  logic       o_forward_ex_rs1;
  logic       o_forward_ex_rs2;
  logic       o_forward_ls_rs1;
  logic       o_forward_ls_rs2;
  logic       o_md_start;
  logic       o_md_kill;
  logic       o_md_busy;

  modport slave (
    input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_ren, i_id_rs2_ren,
    input  i_id_rd_addr, i_id_rd_wen, i_id_mem_read, i_id_is_muldiv, i_id_is_div,
    input  i_ls_ready, i_flush,
    output o_id_ready, o_ex_valid, o_forward_ex_rs1, o_forward_ex_rs2,
    output o_forward_ls_rs1, o_forward_ls_rs2, o_md_start, o_md_kill, o_md_busy
  );

  modport master (
    output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_ren, i_id_rs2_ren,
    output i_id_rd_addr, i_id_rd_wen, i_id_mem_read, i_id_is_muldiv, i_id_is_div,
    output i_ls_ready, i_flush,
    input  o_id_ready, o_ex_valid, o_forward_ex_rs1, o_forward_ex_rs2,
    input  o_forward_ls_rs1, o_forward_ls_rs2, o_md_start, o_md_kill, o_md_busy
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: hazard tracking, forwarding selects, load-use bubbles
// and mul/div sequencing. The mul/div FSM is built only when EXU_MULDIV_EN is defined.
module ex_issue_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_issue_ctrl_if.slave       ex_io
);

  function automatic logic src_match(input logic ren, input logic [4:0] src, input logic vld,
                                     input logic wen, input logic [4:0] rd);
    return ren & vld & wen & (rd == src) & (src != 5'd0);
  endfunction

  logic       ex_valid_q, ex_valid_d, ex_wen_q, ex_wen_d, ex_load_q, ex_load_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ls_valid_q, ls_valid_d, ls_wen_q, ls_wen_d;
  logic [4:0] ls_rd_q, ls_rd_d;
  logic [3:0] fwd_q, fwd_d;  // {ex_rs1, ex_rs2, ls_rs1, ls_rs2}
  logic       hold, adv, load_use, accept;
  logic       rs1_ex, rs2_ex, rs1_ls, rs2_ls;

  assign rs1_ex = src_match(ex_io.i_id_rs1_ren, ex_io.i_id_rs1_addr, ex_valid_q, ex_wen_q, ex_rd_q);
  assign rs2_ex = src_match(ex_io.i_id_rs2_ren, ex_io.i_id_rs2_addr, ex_valid_q, ex_wen_q, ex_rd_q);
  assign rs1_ls = src_match(ex_io.i_id_rs1_ren, ex_io.i_id_rs1_addr, ls_valid_q, ls_wen_q, ls_rd_q);
  assign rs2_ls = src_match(ex_io.i_id_rs2_ren, ex_io.i_id_rs2_addr, ls_valid_q, ls_wen_q, ls_rd_q);

  assign load_use = ex_load_q & (rs1_ex | rs2_ex);
  assign adv      = ex_io.i_ls_ready & ~hold;
  assign accept   = ex_io.i_id_valid & adv & ~load_use & ~ex_io.i_flush;

  assign ex_io.o_id_ready       = accept;
  assign ex_io.o_ex_valid       = ex_valid_q;
  assign ex_io.o_forward_ex_rs1 = fwd_q[3];
  assign ex_io.o_forward_ex_rs2 = fwd_q[2];
  assign ex_io.o_forward_ls_rs1 = fwd_q[1];
  assign ex_io.o_forward_ls_rs2 = fwd_q[0];

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    ex_wen_d   = ex_wen_q;
    ex_load_d  = ex_load_q;
    ls_valid_d = ls_valid_q;
    ls_rd_d    = ls_rd_q;
    ls_wen_d   = ls_wen_q;
    fwd_d      = fwd_q;
    if (adv) begin
      // A flushed EX instruction is dead, so LS receives a bubble in its place.
      ls_valid_d = ex_valid_q & ~ex_io.i_flush;
      ls_rd_d    = ex_rd_q;
      ls_wen_d   = ex_wen_q;
      ex_valid_d = accept;
      ex_rd_d    = ex_io.i_id_rd_addr;
      ex_wen_d   = ex_io.i_id_rd_wen;
      ex_load_d  = ex_io.i_id_mem_read;
      fwd_d      = accept ? {rs1_ex, rs2_ex, rs1_ls & ~rs1_ex, rs2_ls & ~rs2_ex} : 4'b0000;
    end
    if (ex_io.i_flush) begin
      ex_valid_d = 1'b0;
      fwd_d      = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_wen_q   <= 1'b0;
      ex_load_q  <= 1'b0;
      ls_valid_q <= 1'b0;
      ls_rd_q    <= 5'd0;
      ls_wen_q   <= 1'b0;
      fwd_q      <= 4'b0000;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_wen_q   <= ex_wen_d;
      ex_load_q  <= ex_load_d;
      ls_valid_q <= ls_valid_d;
      ls_rd_q    <= ls_rd_d;
      ls_wen_q   <= ls_wen_d;
      fwd_q      <= fwd_d;
    end
  end

`ifdef EXU_MULDIV_EN
  localparam logic StIdle   = 1'b0;
  localparam logic StMdBusy = 1'b1;
  localparam logic [5:0] MulCnt = 6'(MUL_LAT - 1);
  localparam logic [5:0] DivCnt = 6'(DIV_LAT - 1);

  logic       state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       md_start_q, md_start_d, md_kill_q, md_kill_d;

  assign hold             = (state_q == StMdBusy) & (cnt_q != 6'd0);
  assign ex_io.o_md_busy  = hold;
  assign ex_io.o_md_start = md_start_q;
  assign ex_io.o_md_kill  = md_kill_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    md_kill_d  = 1'b0;
    if (ex_io.i_flush) begin
      md_kill_d = (state_q == StMdBusy);
      state_d   = StIdle;
      cnt_d     = 6'd0;
    end else if (hold) begin
      // The unit runs internally, so counting ignores i_ls_ready.
      cnt_d = cnt_q - 6'd1;
    end else if (adv) begin
      if (accept & ex_io.i_id_is_muldiv) begin
        state_d    = StMdBusy;
        cnt_d      = ex_io.i_id_is_div ? DivCnt : MulCnt;
        md_start_d = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      md_start_q <= 1'b0;
      md_kill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_kill_q  <= md_kill_d;
    end
  end
`else
  assign hold             = 1'b0;
  assign ex_io.o_md_busy  = 1'b0;
  assign ex_io.o_md_start = 1'b0;
  assign ex_io.o_md_kill  = 1'b0;
`endif

endmodule
